// File: rtl/peripheral_mpi_bb_mc_if.sv
// peripheral_mpi_bb_mc bus bundle: NoC lanes, BlackBone slave port, irq.
// slave = buffer side, master = tile/network side.
interface peripheral_mpi_bb_mc_if #(
  parameter int N = 2,
  parameter int W = 32
);
  logic [N*W-1:0] noc_out_flit;
  logic [N-1:0]   noc_out_last;
  logic [N-1:0]   noc_out_valid;
  logic [N-1:0]   noc_out_ready;
  logic [N*W-1:0] noc_in_flit;
  logic [N-1:0]   noc_in_last;
  logic [N-1:0]   noc_in_valid;
  logic [N-1:0]   noc_in_ready;
  logic [31:0]    bb_addr_i;
  logic [31:0]    bb_din_i;
  logic           bb_en_i;
  logic           bb_we_i;
  logic [31:0]    bb_dout_o;
  logic           irq;

  modport slave (
    output noc_out_flit, noc_out_last, noc_out_valid,
    input  noc_out_ready,
    input  noc_in_flit, noc_in_last, noc_in_valid,
    output noc_in_ready,
    input  bb_addr_i, bb_din_i, bb_en_i, bb_we_i,
    output bb_dout_o, irq
  );

  modport master (
    input  noc_out_flit, noc_out_last, noc_out_valid,
    output noc_out_ready,
    output noc_in_flit, noc_in_last, noc_in_valid,
    input  noc_in_ready,
    output bb_addr_i, bb_din_i, bb_en_i, bb_we_i,
    input  bb_dout_o, irq
  );
endinterface

// File: rtl/peripheral_mpi_bb_mc.sv
// Multi-lane MPI message buffer behind a BlackBone slave port.
// Optional PERIPHERAL_MPI_TX_IRQ_EN adds a sticky tx_done irq source.
module peripheral_mpi_bb_mc #(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int SIZE = 16,
  parameter int N = 2
) (
  input logic clk,
  input logic rst,
  peripheral_mpi_bb_mc_if.slave bus
);
  localparam int W  = NOC_FLIT_WIDTH;
  localparam int AW = $clog2(SIZE);
  localparam int LW = AW + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {TX_IDLE, TX_SEND} tx_st_t;
  typedef enum logic {RX_RECV, RX_HOLD} rx_st_t;

  logic [3:0]    ch;
  logic [1:0]    rsel;
  logic          ch_ok;
  logic [CW-1:0] idx;
  logic [31:0]   rd_word [N];
  logic [N-1:0]  irq_src;
  logic          unused_addr;

  assign ch    = bus.bb_addr_i[7:4];
  assign rsel  = bus.bb_addr_i[3:2];
  assign ch_ok = 32'(ch) < N;
  assign idx   = ch[CW-1:0];
  assign unused_addr = ^{bus.bb_addr_i[31:8],
                         bus.bb_addr_i[1:0]};

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic sel, wr_data, wr_ctrl, rd_data;
    logic [W-1:0] tx_mem [SIZE];
    logic [W-1:0] rx_mem [SIZE];
    tx_st_t tx_st;
    rx_st_t rx_st;
    logic [LW-1:0] tx_cnt, rx_cnt, rx_len;
    logic [AW-1:0] tx_rd, rx_rd;
    logic tx_err, rx_ovf, irq_en, tx_done;
    logic tx_fire, tx_end, tx_push;
    logic rx_fire, rx_full, rx_pop;
    logic [31:0] word;

    assign sel = bus.bb_en_i & ch_ok & (idx == CW'(i));
    assign wr_data = sel & bus.bb_we_i & (rsel == 2'd0);
    assign wr_ctrl = sel & bus.bb_we_i & (rsel == 2'd2);
    assign rd_data = sel & ~bus.bb_we_i & (rsel == 2'd0);

    assign tx_fire = (tx_st == TX_SEND)
                   & bus.noc_out_ready[i];
    assign tx_end  = tx_fire
                   & ((LW'(tx_rd) + LW'(1)) == tx_cnt);
    assign tx_push = wr_data & (tx_st == TX_IDLE)
                   & (tx_cnt != LW'(SIZE));
    assign rx_fire = (rx_st == RX_RECV)
                   & bus.noc_in_valid[i];
    assign rx_full = (rx_cnt == LW'(SIZE));
    assign rx_pop  = rd_data & (rx_st == RX_HOLD);

    always_ff @(posedge clk) begin
      if (tx_push)
        tx_mem[tx_cnt[AW-1:0]] <= W'(bus.bb_din_i);
      if (rx_fire && !rx_full)
        rx_mem[rx_cnt[AW-1:0]] <= bus.noc_in_flit[i*W +: W];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tx_st  <= TX_IDLE;
        tx_cnt <= '0;
        tx_rd  <= '0;
        tx_err <= 1'b0;
        irq_en <= 1'b0;
      end else begin
        if (wr_data && !tx_push)
          tx_err <= 1'b1;
        if (wr_ctrl) begin
          irq_en <= bus.bb_din_i[1];
          if (bus.bb_din_i[2])
            tx_err <= 1'b0;
        end
        unique case (tx_st)
          TX_IDLE: begin
            if (tx_push)
              tx_cnt <= tx_cnt + LW'(1);
            if (wr_ctrl && bus.bb_din_i[0]
                && tx_cnt != '0)
              tx_st <= TX_SEND;
          end
          TX_SEND: begin
            if (tx_end) begin
              tx_st  <= TX_IDLE;
              tx_cnt <= '0;
              tx_rd  <= '0;
            end else if (tx_fire) begin
              tx_rd <= tx_rd + AW'(1);
            end
          end
        endcase
      end
    end

`ifdef PERIPHERAL_MPI_TX_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        tx_done <= 1'b0;
      else if (tx_end)
        tx_done <= 1'b1;
      else if (wr_ctrl && bus.bb_din_i[2])
        tx_done <= 1'b0;
    end
`else
    assign tx_done = 1'b0;
`endif

    // Flits past SIZE are accepted but dropped; the message still closes on last.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rx_st  <= RX_RECV;
        rx_cnt <= '0;
        rx_rd  <= '0;
        rx_len <= '0;
        rx_ovf <= 1'b0;
      end else begin
        if (wr_ctrl && bus.bb_din_i[2])
          rx_ovf <= 1'b0;
        unique case (rx_st)
          RX_RECV: begin
            if (rx_fire) begin
              if (rx_full)
                rx_ovf <= 1'b1;
              if (bus.noc_in_last[i]) begin
                rx_st  <= RX_HOLD;
                rx_rd  <= '0;
                rx_cnt <= '0;
                rx_len <= rx_full ? rx_cnt
                                  : rx_cnt + LW'(1);
              end else if (!rx_full) begin
                rx_cnt <= rx_cnt + LW'(1);
              end
            end
          end
          RX_HOLD: begin
            if (rx_pop) begin
              rx_rd  <= rx_rd + AW'(1);
              rx_len <= rx_len - LW'(1);
              if (rx_len == LW'(1))
                rx_st <= RX_RECV;
            end
          end
        endcase
      end
    end

    assign bus.noc_out_valid[i] = (tx_st == TX_SEND);
    assign bus.noc_out_last[i]  = (tx_st == TX_SEND)
      & ((LW'(tx_rd) + LW'(1)) == tx_cnt);
    assign bus.noc_out_flit[i*W +: W] =
      (tx_st == TX_SEND) ? tx_mem[tx_rd] : '0;
    assign bus.noc_in_ready[i] = (rx_st == RX_RECV);

    always_comb begin
      word = '0;
      unique case (rsel)
        2'd0: word = (rx_st == RX_HOLD)
                   ? rx_mem[rx_rd][31:0] : '0;
        2'd1: word = {15'b0, 9'(rx_len), 2'b0,
                      tx_done, rx_ovf, tx_err,
                      tx_st == TX_SEND,
                      tx_cnt == LW'(SIZE),
                      rx_st == RX_HOLD};
        2'd2: word = {30'b0, irq_en, 1'b0};
        2'd3: word = 32'(tx_cnt);
      endcase
    end

    assign rd_word[i] = word;
    assign irq_src[i] = irq_en
      & ((rx_st == RX_HOLD) | tx_done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.bb_dout_o <= '0;
    else if (bus.bb_en_i && !bus.bb_we_i)
      bus.bb_dout_o <= ch_ok ? rd_word[idx] : '0;
  end

  assign bus.irq = |irq_src;
endmodule

// File: doc/peripheral_mpi_bb_mc.md
Name: peripheral_mpi_bb_mc

Overview:
Multi-channel MPI message buffer with BlackBone bus slave interface; next generation of the single-lane MPI endpoint. Provides N independent NoC lanes (virtual channels), each with its own SIZE-flit TX and RX message buffer, a per-lane TX/RX state machine, sticky error flags and a per-lane interrupt enable. Sits between the tile CPU's BlackBone bus and the NoC network adapter.

Parameters:
NOC_FLIT_WIDTH, 32, flit width in bits (>=32; bus sees low 32 bits, upper bits zero-filled on TX)
SIZE, 16, flits per TX and per RX buffer; power of two, 2..256
N, 2, number of NoC lanes/channels, 1..16

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
noc_out_flit  out  N*NOC_FLIT_WIDTH  TX flits, lane i at [i*W+:W]
noc_out_last  out  N  last flit of message, per lane
noc_out_valid  out  N  TX valid, per lane
noc_out_ready  in  N  TX ready, per lane
noc_in_flit  in  N*NOC_FLIT_WIDTH  RX flits, per lane
noc_in_last  in  N  RX last, per lane
noc_in_valid  in  N  RX valid, per lane
noc_in_ready  out  N  RX ready, per lane
bb_addr_i  in  32  byte address; [7:4] channel, [3:2] register
bb_din_i  in  32  write data
bb_en_i  in  1  access strobe, one access per cycle
bb_we_i  in  1  1 = write, 0 = read
bb_dout_o  out  32  read data
irq  out  1  OR of enabled per-channel interrupt sources

Behaviour:
- Reset (async, rst=1): all FSMs IDLE, pointers/counters 0, sticky flags 0, irq_en 0; noc_out_valid=0, noc_out_last=0, noc_out_flit=0, noc_in_ready=1 for all lanes, bb_dout_o=0, irq=0. Reset mid-message discards all buffered flits.
- Channel index >= N: reads return 0, writes ignored.
- Registers per channel: 0x0 DATA (W: push TX flit; R: pop RX flit). 0x4 STATUS (R): bit0 rx_avail, bit1 tx_full, bit2 tx_busy, bit3 tx_err, bit4 rx_ovf, bits[16:8] rx_len (head message length, flits remaining). 0x8 CTRL: W bit0 send, bit1 irq_en (stored), bit2 clear tx_err/rx_ovf; R returns bit1 irq_en. 0xC TXCNT (R): flits in TX buffer.
- Reads: bb_dout_o registered, valid the cycle after bb_en_i&~bb_we_i; holds value until next read. DATA pop takes effect in the access cycle.
- TX FSM per lane: IDLE -> SEND on CTRL.send with count>0 (send with count 0 ignored). SEND: noc_out_valid=1, flit = buffer[rd_ptr]; advance on valid&ready; noc_out_last=1 on final flit; after final handshake -> IDLE, count=0, pointers 0. Flit/last stable while valid&~ready.
- TX DATA write when count==SIZE or in SEND: dropped, tx_err set. tx_full = (count==SIZE); tx_busy = SEND.
- RX FSM per lane: RECV (noc_in_ready=1) stores flits; on last handshake -> HOLD (noc_in_ready=0), rx_len = flits stored, rx_avail=1. HOLD: each DATA read returns next flit, rx_len-1; when rx_len reaches 0 -> RECV in same cycle as final pop (noc_in_ready=1 next cycle).
- DATA read in RECV: returns 0, no pop.
- RX overflow: flits beyond SIZE in one message accepted and discarded, rx_ovf set; message still delivered (first SIZE flits) on last.
- Single-flit message (valid&last first flit) valid, rx_len=1.
- irq = OR over channels of (rx_avail & irq_en); combinational from registered state.
- Lanes fully independent; concurrent TX on all lanes permitted.

Optional Feature:
PERIPHERAL_MPI_TX_IRQ_EN: defined -> per-channel sticky tx_done flag (STATUS bit5) set when SEND completes, cleared by CTRL bit2; irq additionally ORs (tx_done & irq_en). Undefined -> STATUS bit5 reads 0, no TX interrupt logic.

Test Plan:
- Reset: assert rst mid-SEND on lane 0 -> noc_out_valid=0, noc_in_ready=2'b11, irq=0, TXCNT=0 immediately (async).
- TX ch1: write DATA 0xA1,0xA2,0xA3, CTRL=1, noc_out_ready toggling 1/0 -> lane1 emits A1,A2,A3 in order, last only on A3, flit stable during stalls, TXCNT=0 after.
- TX overflow: 17 DATA writes ch0 (SIZE=16) -> TXCNT=16, STATUS.tx_err=1; CTRL=4 clears it.
- RX ch0 with irq_en=1: inject 0x11,0x22(last) -> noc_in_ready=0, rx_len=2, irq=1; two DATA reads return 0x11,0x22; irq=0, ready=1 after.
- RX overflow: inject 20 flits, last on 20th -> rx_ovf=1, rx_len=16, reads return flits 1..16.
- Concurrency: simultaneous RX on lane0 and TX on lane1 -> both complete, no cross-lane corruption; read of channel 5 returns 0.
